// File: rtl/boss_chaser.sv
// rtl/boss_chaser.sv - boss movement and contact-detection engine for stage 3
//
// Purpose:
//   Walks the boss one pixel per step tick toward the player, along the axis
//   with the larger distance. Each candidate pixel is checked against the
//   shared map through a probe request/acknowledge handshake. The boss moves
//   only when the map reports that the pixel is not a wall. Contact is
//   reported on a level output. The game-play controller uses it to leave
//   the stage.
//
// Optional feature:
//   BOSS_SLIDE_EN - when the primary-axis probe is blocked, issue one more
//   probe on the secondary axis. The boss slides along the wall instead of
//   stopping.
//
// Ports:
//   clk           in   1  system clock
//   rst           in   1  asynchronous active-low reset
//   enable        in   1  high while the controller is in STAGE3
//   player_x/y    in   9  player pixel position
//   probe_req     out  1  wall-check request for (probe_x, probe_y)
//   probe_x/y     out  9  candidate boss pixel
//   probe_ack     in   1  map lookup result valid (may be combinational on req)
//   probe_blocked in   1  candidate is a wall, sampled with probe_ack
//   boss_x/y      out  9  boss pixel position
//   boss_state    out  4  sprite code: UP1..3=0..2, RIGHT1..3=3..5,
//                         LEFT1..3=6..8, DOWN1..3=9..11
//   caught        out  1  boss touched player (level)

module boss_chaser #(
   parameter int unsigned STEP_DIV    = 4194304,
   parameter int unsigned START_DELAY = 32,
   parameter int unsigned HIT_RADIUS  = 4,
   parameter logic [8:0]  SPAWN_X     = 9'd260,
   parameter logic [8:0]  SPAWN_Y     = 9'd130
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [8:0] player_x,
   input  logic [8:0] player_y,
   output logic       probe_req,
   output logic [8:0] probe_x,
   output logic [8:0] probe_y,
   input  logic       probe_ack,
   input  logic       probe_blocked,
   output logic [8:0] boss_x,
   output logic [8:0] boss_y,
   output logic [3:0] boss_state,
   output logic       caught
);

   localparam int TW = $clog2(STEP_DIV);
   localparam int DW = $clog2(START_DELAY + 2);

   localparam logic [TW-1:0] TICK_LAST = TW'(STEP_DIV - 1);
   localparam logic [DW-1:0] DELAY_END = DW'(START_DELAY);
   localparam logic [8:0]    RADIUS    = 9'(HIT_RADIUS);

   localparam logic [3:0] SPR_UP    = 4'd0;
   localparam logic [3:0] SPR_RIGHT = 4'd3;
   localparam logic [3:0] SPR_LEFT  = 4'd6;
   localparam logic [3:0] SPR_DOWN  = 4'd9;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DELAY,
      S_DECIDE,
      S_PROBE,
      S_MOVE,
      S_CAUGHT,
      S_SLIDE
   } state_t;

   state_t state_q;

   // ------------------------------------------------------------------
   // Step tick: free-running divider, only while the stage is active.
   // ------------------------------------------------------------------
   logic [TW-1:0] tick_cnt_q;
   logic [TW-1:0] tick_cnt_d;
   logic          tick;

   always_comb begin
      tick       = 1'b0;
      tick_cnt_d = tick_cnt_q;
      if (!enable) begin
         tick_cnt_d = '0;
      end else if (tick_cnt_q == TICK_LAST) begin
         tick       = 1'b1;
         tick_cnt_d = '0;
      end else begin
         tick_cnt_d = tick_cnt_q + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Player-relative geometry
   // ------------------------------------------------------------------
   logic [9:0] dx;
   logic [9:0] dy;
   logic [8:0] adx;
   logic [8:0] ady;
   logic       hit;
   logic       pri_y;     // primary axis is y (x wins ties)
   logic       pri_neg;   // step toward decreasing coordinate
   logic       pri_zero;
   logic [8:0] cand_x;
   logic [8:0] cand_y;

   always_comb begin
      dx = {1'b0, player_x} - {1'b0, boss_x};
      dy = {1'b0, player_y} - {1'b0, boss_y};
      // |delta| always fits in 9 bits since both operands are 9-bit unsigned
      adx = dx[9] ? (~dx[8:0] + 9'd1) : dx[8:0];
      ady = dy[9] ? (~dy[8:0] + 9'd1) : dy[8:0];
      hit = (adx <= RADIUS) && (ady <= RADIUS);

      pri_y    = (adx < ady);
      pri_neg  = pri_y ? dy[9] : dx[9];
      pri_zero = pri_y ? (dy == 10'd0) : (dx == 10'd0);

      cand_x = boss_x;
      cand_y = boss_y;
      if (pri_y) begin
         cand_y = pri_neg ? (boss_y - 9'd1) : (boss_y + 9'd1);
      end else begin
         cand_x = pri_neg ? (boss_x - 9'd1) : (boss_x + 9'd1);
      end
   end

   // ------------------------------------------------------------------
   // Sprite helpers
   // ------------------------------------------------------------------
   logic       step_y_q;    // axis of the outstanding probe (1 = y)
   logic       step_neg_q;  // direction of the outstanding probe
   logic [3:0] face_base;   // current sprite with frame forced to 1
   logic [3:0] dir_base;    // frame-1 sprite for the probe direction
   logic [3:0] move_sprite;

   always_comb begin
      if (boss_state >= SPR_DOWN) begin
         face_base = SPR_DOWN;
      end else if (boss_state >= SPR_LEFT) begin
         face_base = SPR_LEFT;
      end else if (boss_state >= SPR_RIGHT) begin
         face_base = SPR_RIGHT;
      end else begin
         face_base = SPR_UP;
      end

      if (step_y_q) begin
         dir_base = step_neg_q ? SPR_UP : SPR_DOWN;
      end else begin
         dir_base = step_neg_q ? SPR_LEFT : SPR_RIGHT;
      end

      // Walk cycle alternates frames 2 and 3; any other frame restarts at 2.
      move_sprite = dir_base + (((boss_state - face_base) == 4'd1) ? 4'd2 : 4'd1);
   end

`ifdef BOSS_SLIDE_EN
   logic       slide_q;   // the outstanding probe is already the secondary one
   logic [9:0] sec_d;
   logic       sec_neg;
   logic       sec_zero;

   always_comb begin
      sec_d    = step_y_q ? dx : dy;
      sec_neg  = sec_d[9];
      sec_zero = (sec_d == 10'd0);
   end
`endif

   // ------------------------------------------------------------------
   // Chase FSM
   // ------------------------------------------------------------------
   logic [DW-1:0] delay_cnt_q;
   logic          in_play;

   assign in_play = (state_q == S_DELAY) || (state_q == S_DECIDE) ||
                    (state_q == S_PROBE) || (state_q == S_MOVE) ||
                    (state_q == S_SLIDE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         delay_cnt_q <= '0;
         step_y_q    <= 1'b0;
         step_neg_q  <= 1'b0;
         probe_req   <= 1'b0;
         probe_x     <= 9'd0;
         probe_y     <= 9'd0;
         boss_x      <= SPAWN_X;
         boss_y      <= SPAWN_Y;
         boss_state  <= SPR_LEFT;
         caught      <= 1'b0;
`ifdef BOSS_SLIDE_EN
         slide_q     <= 1'b0;
`endif
      end else if (!enable) begin
         state_q     <= S_IDLE;
         delay_cnt_q <= '0;
         probe_req   <= 1'b0;
         boss_x      <= SPAWN_X;
         boss_y      <= SPAWN_Y;
         boss_state  <= SPR_LEFT;
         caught      <= 1'b0;
      end else if (in_play && hit) begin
         // Contact wins over any probe or step in flight.
         state_q   <= S_CAUGHT;
         probe_req <= 1'b0;
         caught    <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               delay_cnt_q <= '0;
               state_q     <= S_DELAY;
            end

            S_DELAY: begin
               if (delay_cnt_q == DELAY_END) begin
                  state_q <= S_DECIDE;
               end else if (tick) begin
                  delay_cnt_q <= delay_cnt_q + DW'(1);
               end
            end

            S_DECIDE: begin
               if (tick) begin
                  if (pri_zero) begin
                     boss_state <= face_base;
                  end else begin
                     probe_x    <= cand_x;
                     probe_y    <= cand_y;
                     step_y_q   <= pri_y;
                     step_neg_q <= pri_neg;
                     probe_req  <= 1'b1;
                     state_q    <= S_PROBE;
`ifdef BOSS_SLIDE_EN
                     slide_q    <= 1'b0;
`endif
                  end
               end
            end

            S_PROBE: begin
               if (probe_ack) begin
                  probe_req <= 1'b0;
                  if (!probe_blocked) begin
                     state_q <= S_MOVE;
                  end else begin
`ifdef BOSS_SLIDE_EN
                     if (!slide_q && !sec_zero) begin
                        // Re-aim on the other axis; req drops for one cycle
                        // so the map sees a fresh request.
                        if (step_y_q) begin
                           probe_x <= sec_neg ? (boss_x - 9'd1) : (boss_x + 9'd1);
                           probe_y <= boss_y;
                        end else begin
                           probe_x <= boss_x;
                           probe_y <= sec_neg ? (boss_y - 9'd1) : (boss_y + 9'd1);
                        end
                        step_y_q   <= !step_y_q;
                        step_neg_q <= sec_neg;
                        slide_q    <= 1'b1;
                        state_q    <= S_SLIDE;
                     end else begin
                        boss_state <= face_base;
                        state_q    <= S_DECIDE;
                     end
`else
                     boss_state <= face_base;
                     state_q    <= S_DECIDE;
`endif
                  end
               end
            end

            S_SLIDE: begin
               probe_req <= 1'b1;
               state_q   <= S_PROBE;
            end

            S_MOVE: begin
               boss_x     <= probe_x;
               boss_y     <= probe_y;
               boss_state <= move_sprite;
               state_q    <= S_DECIDE;
            end

            S_CAUGHT: begin
               probe_req <= 1'b0;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_boss_chaser.sv
// tb/tb_boss_chaser.sv - self-checking bench for boss_chaser

module tb_boss_chaser;

   localparam int STEP_DIV    = 4;
   localparam int START_DELAY = 2;
   localparam int HIT_RADIUS  = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       enable = 1'b0;
   logic [8:0] player_x = 9'd0;
   logic [8:0] player_y = 9'd0;
   logic       man_ack = 1'b0;
   logic       tie_ack = 1'b0;
   logic       probe_blocked = 1'b0;
   logic       probe_ack_w;
   logic       probe_req;
   logic [8:0] probe_x;
   logic [8:0] probe_y;
   logic [8:0] boss_x;
   logic [8:0] boss_y;
   logic [3:0] boss_state;
   logic       caught;

   int n_cmp = 0;
   int n_err = 0;

   assign probe_ack_w = tie_ack ? probe_req : man_ack;

   always #5 clk = ~clk;

   boss_chaser #(
      .STEP_DIV   (STEP_DIV),
      .START_DELAY(START_DELAY),
      .HIT_RADIUS (HIT_RADIUS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .player_x     (player_x),
      .player_y     (player_y),
      .probe_req    (probe_req),
      .probe_x      (probe_x),
      .probe_y      (probe_y),
      .probe_ack    (probe_ack_w),
      .probe_blocked(probe_blocked),
      .boss_x       (boss_x),
      .boss_y       (boss_y),
      .boss_state   (boss_state),
      .caught       (caught)
   );

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic wait_req(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (probe_req) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic give_ack(input bit blocked);
      man_ack       = 1'b1;
      probe_blocked = blocked;
      @(negedge clk);
      man_ack       = 1'b0;
      probe_blocked = 1'b0;
   endtask

   task automatic restart(input int px, input int py);
      enable = 1'b0;
      repeat (2) @(negedge clk);
      player_x = 9'(px);
      player_y = 9'(py);
      enable   = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (boss_x !== 9'd260) begin n_err++; $display("FAIL reset_boss_x: got %0d expected 260", boss_x); end
      n_cmp++; if (boss_y !== 9'd130) begin n_err++; $display("FAIL reset_boss_y: got %0d expected 130", boss_y); end
      n_cmp++; if (boss_state !== 4'd6) begin n_err++; $display("FAIL reset_state: got %0d expected 6", boss_state); end
      n_cmp++; if (caught !== 1'b0) begin n_err++; $display("FAIL reset_caught: got %0d expected 0", caught); end
      n_cmp++; if (probe_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %0d expected 0", probe_req); end
      n_cmp++; if ({probe_x, probe_y} !== 18'd0) begin n_err++; $display("FAIL reset_probe: got (%0d,%0d) expected (0,0)", probe_x, probe_y); end
   endtask

   task automatic test_start_delay;
      int early;
      bit ok;
      early    = 0;
      tie_ack  = 1'b1;
      player_x = 9'd100;
      player_y = 9'd130;
      enable   = 1'b1;
      for (int i = 0; i < 2 * STEP_DIV; i++) begin
         @(negedge clk);
         if (probe_req) early++;
      end
      n_cmp++; if (early != 0) begin n_err++; $display("FAIL start_delay_quiet: got %0d early req cycles expected 0", early); end
      wait_req(20, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL first_probe_timeout: got no req expected req"); end
      n_cmp++; if (probe_x !== 9'd259 || probe_y !== 9'd130) begin
         n_err++; $display("FAIL first_probe_xy: got (%0d,%0d) expected (259,130)", probe_x, probe_y);
      end
   endtask

   task automatic test_chase;
      logic [8:0] prev;
      int gap;
      bit found;
      prev = boss_x;
      for (int k = 1; k <= 6; k++) begin
         gap   = 0;
         found = 1'b0;
         while (gap < 20 && !found) begin
            @(negedge clk);
            gap++;
            if (boss_x !== prev) found = 1'b1;
         end
         n_cmp++; if (!found) begin n_err++; $display("FAIL chase_step_timeout: got none expected step %0d", k); end
         n_cmp++; if (boss_x !== 9'(260 - k) || boss_y !== 9'd130) begin
            n_err++; $display("FAIL chase_pos: got (%0d,%0d) expected (%0d,130)", boss_x, boss_y, 260 - k);
         end
         n_cmp++; if (boss_state !== (((k % 2) == 1) ? 4'd7 : 4'd8)) begin
            n_err++; $display("FAIL chase_sprite: got %0d expected %0d", boss_state, ((k % 2) == 1) ? 7 : 8);
         end
         if (k > 1) begin
            n_cmp++; if (gap < STEP_DIV) begin n_err++; $display("FAIL chase_rate: got gap %0d expected >= %0d", gap, STEP_DIV); end
         end
         prev = boss_x;
      end
   endtask

   task automatic test_caught;
      int bad;
      tie_ack       = 1'b1;
      probe_blocked = 1'b1;
      restart(100, 130);
      repeat (20) @(negedge clk);
      n_cmp++; if (boss_x !== 9'd260 || boss_y !== 9'd130 || boss_state !== 4'd6) begin
         n_err++; $display("FAIL blocked_hold: got (%0d,%0d,%0d) expected (260,130,6)", boss_x, boss_y, boss_state);
      end
      n_cmp++; if (caught !== 1'b0) begin n_err++; $display("FAIL caught_before: got %0d expected 0", caught); end
      player_x = 9'd258;
      player_y = 9'd131;
      @(negedge clk);
      n_cmp++; if (caught !== 1'b1) begin n_err++; $display("FAIL caught_latency: got %0d expected 1", caught); end
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (caught !== 1'b1 || boss_x !== 9'd260 || boss_y !== 9'd130 || probe_req !== 1'b0) bad++;
      end
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL caught_frozen: got %0d bad cycles expected 0", bad); end
      enable = 1'b0;
      @(negedge clk);
      n_cmp++; if (caught !== 1'b0) begin n_err++; $display("FAIL caught_clear: got %0d expected 0", caught); end
      n_cmp++; if (boss_x !== 9'd260 || boss_y !== 9'd130 || boss_state !== 4'd6) begin
         n_err++; $display("FAIL respawn: got (%0d,%0d,%0d) expected (260,130,6)", boss_x, boss_y, boss_state);
      end
      probe_blocked = 1'b0;
      tie_ack       = 1'b0;
   endtask

   task automatic test_blocked_slide;
      bit ok;
      tie_ack = 1'b0;
      restart(200, 100);
      wait_req(60, ok);
      n_cmp++; if (!ok || probe_x !== 9'd259 || probe_y !== 9'd130) begin
         n_err++; $display("FAIL slide_primary: got (%0d,%0d) req %0d expected (259,130)", probe_x, probe_y, ok);
      end
      give_ack(1'b1);
`ifdef BOSS_SLIDE_EN
      wait_req(10, ok);
      n_cmp++; if (!ok || probe_x !== 9'd260 || probe_y !== 9'd129) begin
         n_err++; $display("FAIL slide_secondary: got (%0d,%0d) req %0d expected (260,129)", probe_x, probe_y, ok);
      end
      give_ack(1'b0);
      repeat (3) @(negedge clk);
      n_cmp++; if (boss_x !== 9'd260 || boss_y !== 9'd129 || boss_state !== 4'd1) begin
         n_err++; $display("FAIL slide_move: got (%0d,%0d,%0d) expected (260,129,1)", boss_x, boss_y, boss_state);
      end
`else
      repeat (3) @(negedge clk);
      n_cmp++; if (boss_x !== 9'd260 || boss_y !== 9'd130 || boss_state !== 4'd6) begin
         n_err++; $display("FAIL blocked_stay: got (%0d,%0d,%0d) expected (260,130,6)", boss_x, boss_y, boss_state);
      end
      wait_req(20, ok);
      n_cmp++; if (!ok || probe_x !== 9'd259 || probe_y !== 9'd130) begin
         n_err++; $display("FAIL no_secondary: got (%0d,%0d) req %0d expected (259,130)", probe_x, probe_y, ok);
      end
`endif
   endtask

   task automatic test_ack_stall;
      bit ok;
      int bad;
      logic [8:0] hx;
      logic [8:0] hy;
      tie_ack = 1'b0;
      restart(100, 130);
      wait_req(60, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL stall_req_timeout: got no req expected req"); end
      hx  = probe_x;
      hy  = probe_y;
      bad = 0;
      for (int i = 0; i < 20 * STEP_DIV; i++) begin
         @(negedge clk);
         if (probe_req !== 1'b1 || probe_x !== hx || probe_y !== hy) bad++;
      end
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL stall_hold: got %0d bad cycles expected 0", bad); end
      enable = 1'b0;
      @(negedge clk);
      n_cmp++; if (probe_req !== 1'b0) begin n_err++; $display("FAIL stall_drop: got %0d expected 0", probe_req); end
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (probe_req !== 1'b0 || boss_x !== 9'd260 || boss_y !== 9'd130) bad++;
      end
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL stall_idle: got %0d bad cycles expected 0", bad); end
   endtask

   task automatic test_random;
      int px, py, mx, my, mface, mframe, dxm, dym, ex, ey;
      bit pend, paxis_x, ax, neg, ok, b;
      int d;
      tie_ack = 1'b0;
      for (int r = 0; r < 10; r++) begin
         do px = int'($urandom_range(0, 511)); while (px >= 210 && px <= 310);
         py = int'($urandom_range(0, 511));
         restart(px, py);
         mx = 260; my = 130; mface = 2; mframe = 1; pend = 1'b0; paxis_x = 1'b0;
         for (int s = 0; s < 8; s++) begin
            wait_req(60, ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL rnd_req_timeout: round %0d step %0d got none", r, s); break; end
            n_cmp++; if (boss_x !== 9'(mx) || boss_y !== 9'(my) || boss_state !== 4'(mface * 3 + mframe - 1)) begin
               n_err++; $display("FAIL rnd_boss: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                                 boss_x, boss_y, boss_state, mx, my, mface * 3 + mframe - 1);
            end
            dxm = px - mx;
            dym = py - my;
            ax  = pend ? !paxis_x : (iabs(dxm) >= iabs(dym));
            neg = ax ? (dxm < 0) : (dym < 0);
            ex  = ax ? (neg ? mx - 1 : mx + 1) : mx;
            ey  = ax ? my : (neg ? my - 1 : my + 1);
            n_cmp++; if (probe_x !== 9'(ex) || probe_y !== 9'(ey)) begin
               n_err++; $display("FAIL rnd_probe: got (%0d,%0d) expected (%0d,%0d)", probe_x, probe_y, ex, ey);
            end
            d = int'($urandom_range(0, 3));
            repeat (d) @(negedge clk);
            b = 1'($urandom_range(0, 1));
            give_ack(b);
            if (!b) begin
               mx     = ex;
               my     = ey;
               mface  = ax ? (neg ? 2 : 1) : (neg ? 0 : 3);
               mframe = (mframe == 2) ? 3 : 2;
               pend   = 1'b0;
`ifdef BOSS_SLIDE_EN
            end else if (!pend && ((ax ? dym : dxm) != 0)) begin
               pend    = 1'b1;
               paxis_x = ax;
`endif
            end else begin
               mframe = 1;
               pend   = 1'b0;
            end
         end
         repeat (3) @(negedge clk);
         n_cmp++; if (boss_x !== 9'(mx) || boss_y !== 9'(my) || boss_state !== 4'(mface * 3 + mframe - 1)) begin
            n_err++; $display("FAIL rnd_final: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                              boss_x, boss_y, boss_state, mx, my, mface * 3 + mframe - 1);
         end
      end
   endtask

   task automatic test_async_reset;
      bit ok;
      tie_ack = 1'b0;
      restart(100, 130);
      wait_req(60, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL areset_req_timeout: got no req expected req"); end
      #2 rst = 1'b0;
      #1;
      n_cmp++; if (probe_req !== 1'b0) begin n_err++; $display("FAIL areset_req: got %0d expected 0", probe_req); end
      n_cmp++; if (boss_x !== 9'd260 || boss_y !== 9'd130 || caught !== 1'b0) begin
         n_err++; $display("FAIL areset_state: got (%0d,%0d,%0d) expected (260,130,0)", boss_x, boss_y, caught);
      end
      @(negedge clk);
      enable = 1'b0;
      rst    = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_start_delay();
      test_chase();
      test_caught();
      test_blocked_slide();
      test_ack_stall();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
